// File: rtl/mem_arbiter_if.sv
// Unified memory handshake bus between the arbiter (master) and the memory block (slave).
interface mem_arbiter_if;
   logic [31:0] mem_req_addr;
   logic        mem_req_rw;
   logic        mem_req_valid;
   logic [31:0] mem_data_write;
   logic [31:0] mem_data_read;
   logic        mem_ready;

   modport master (
      output mem_req_addr, mem_req_rw, mem_req_valid, mem_data_write,
      input  mem_data_read, mem_ready
   );

   modport slave (
      input  mem_req_addr, mem_req_rw, mem_req_valid, mem_data_write,
      output mem_data_read, mem_ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory handshake port between instruction fetch and data,
// with alignment / write-window filtering and a watchdog on mem_ready.
module mem_arbiter #(
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned CNT_W    = 4,
   parameter logic [31:0] VAR_BASE = 32'h0000_0800,
   parameter logic [31:0] VAR_LAST = 32'h0000_09FC
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_rw,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] d_rdata,
   mem_arbiter_if.master mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef enum logic {GNT_IF, GNT_D} gnt_t;

   state_t           state;
   gnt_t             last_gnt;
   logic [CNT_W-1:0] wd_cnt;

   logic        any_req;
   logic        pick_d;
   logic [31:0] sel_addr;
   logic        sel_rw;
   logic [31:0] sel_wdata;
   logic        illegal;

   // A tie goes to whichever port did not win last; a lone requester always wins.
   always_comb begin
      any_req   = if_req | d_req;
      pick_d    = d_req & (~if_req | (last_gnt == GNT_IF));
      sel_addr  = pick_d ? d_addr : if_addr;
      sel_rw    = pick_d & d_rw;
      sel_wdata = pick_d ? d_wdata : '0;
      illegal   = (sel_addr[1:0] != 2'b00) ||
                  (sel_rw && ((sel_addr < VAR_BASE) || (sel_addr > VAR_LAST)));
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state              <= IDLE;
         last_gnt           <= GNT_D;
         wd_cnt             <= '0;
         if_done            <= 1'b0;
         if_err             <= 1'b0;
         if_rdata           <= '0;
         d_done             <= 1'b0;
         d_err              <= 1'b0;
         d_rdata            <= '0;
         mem.mem_req_addr   <= '0;
         mem.mem_req_rw     <= 1'b0;
         mem.mem_req_valid  <= 1'b0;
         mem.mem_data_write <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  last_gnt           <= pick_d ? GNT_D : GNT_IF;
                  mem.mem_req_addr   <= sel_addr;
                  mem.mem_req_rw     <= sel_rw;
                  mem.mem_data_write <= sel_wdata;
                  wd_cnt             <= '0;
                  if (illegal) begin
                     state <= RESP;
                     if (pick_d) begin
                        d_done  <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= '0;
                     end else begin
                        if_done  <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                     end
                  end else begin
                     state             <= ISSUE;
                     mem.mem_req_valid <= 1'b1;
                  end
               end
            end

            ISSUE: begin
               // Valid stays high on the ready cycle so the memory can clear mem_ready.
               if (mem.mem_ready) begin
                  state             <= RESP;
                  mem.mem_req_valid <= 1'b0;
                  if (last_gnt == GNT_D) begin
                     d_done <= 1'b1;
                     d_err  <= 1'b0;
                     if (!mem.mem_req_rw) d_rdata <= mem.mem_data_read;
                  end else begin
                     if_done  <= 1'b1;
                     if_err   <= 1'b0;
                     if_rdata <= mem.mem_data_read;
                  end
               end else if (wd_cnt == CNT_W'(TIMEOUT)) begin
                  state             <= RESP;
                  mem.mem_req_valid <= 1'b0;
                  if (last_gnt == GNT_D) begin
                     d_done  <= 1'b1;
                     d_err   <= 1'b1;
                     d_rdata <= '0;
                  end else begin
                     if_done  <= 1'b1;
                     if_err   <= 1'b1;
                     if_rdata <= '0;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            RESP: begin
               state   <= IDLE;
               if_done <= 1'b0;
               d_done  <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a one-cycle-latency memory model that can stall.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_done, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_rw = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done, d_err;
   logic [31:0] d_rdata;
   logic        stall = 1'b0;

   mem_arbiter_if mem_bus();

   mem_arbiter #(
      .TIMEOUT (15),
      .CNT_W   (4),
      .VAR_BASE(32'h0000_0800),
      .VAR_LAST(32'h0000_09FC)
   ) dut (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .if_req  (if_req),
      .if_addr (if_addr),
      .if_done (if_done),
      .if_err  (if_err),
      .if_rdata(if_rdata),
      .d_req   (d_req),
      .d_rw    (d_rw),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_done  (d_done),
      .d_err   (d_err),
      .d_rdata (d_rdata),
      .mem     (mem_bus)
   );

   always #5 CLK = ~CLK;

   // Memory: answers one cycle after seeing valid, clears ready when it sees valid&ready.
   logic [31:0] mem_arr [0:1023];
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         mem_bus.mem_ready     <= 1'b0;
         mem_bus.mem_data_read <= '0;
         for (int k = 0; k < 1024; k++) mem_arr[k] <= '0;
         mem_arr[1]   <= 32'hE59F_2200;
         mem_arr[128] <= 32'h0000_0810;
      end else if (mem_bus.mem_req_valid && mem_bus.mem_ready) begin
         mem_bus.mem_ready <= 1'b0;
      end else if (mem_bus.mem_req_valid && !stall) begin
         mem_bus.mem_ready <= 1'b1;
         if (mem_bus.mem_req_rw) mem_arr[mem_bus.mem_req_addr[11:2]] <= mem_bus.mem_data_write;
         else mem_bus.mem_data_read <= mem_arr[mem_bus.mem_req_addr[11:2]];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_d;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stall;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_vcnt;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      //        is_d rw  addr          wdata         stall err rdata         lat vcnt
      vecs[0]  = '{1'b0, 1'b0, 32'h004, 32'h0,         1'b0, 1'b0, 32'hE59F2200, 3,  2};
      vecs[1]  = '{1'b1, 1'b0, 32'h200, 32'h0,         1'b0, 1'b0, 32'h00000810, 3,  2};
      vecs[2]  = '{1'b1, 1'b1, 32'h800, 32'hDEADBEEF,  1'b0, 1'b0, 32'h00000810, 3,  2};
      vecs[3]  = '{1'b1, 1'b0, 32'h800, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF, 3,  2};
      vecs[4]  = '{1'b1, 1'b1, 32'h200, 32'h11111111,  1'b0, 1'b1, 32'h00000000, 1,  0};
      vecs[5]  = '{1'b1, 1'b1, 32'h802, 32'h22222222,  1'b0, 1'b1, 32'h00000000, 1,  0};
      vecs[6]  = '{1'b1, 1'b1, 32'h9FC, 32'hA5A5A5A5,  1'b0, 1'b0, 32'h00000000, 3,  2};
      vecs[7]  = '{1'b1, 1'b0, 32'h9FC, 32'h0,         1'b0, 1'b0, 32'hA5A5A5A5, 3,  2};
      vecs[8]  = '{1'b1, 1'b1, 32'hA00, 32'h33333333,  1'b0, 1'b1, 32'h00000000, 1,  0};
      vecs[9]  = '{1'b1, 1'b1, 32'h7FC, 32'h00000001,  1'b0, 1'b1, 32'h00000000, 1,  0};
      vecs[10] = '{1'b0, 1'b0, 32'h006, 32'h0,         1'b0, 1'b1, 32'h00000000, 1,  0};
      vecs[11] = '{1'b0, 1'b0, 32'h800, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF, 3,  2};
      vecs[12] = '{1'b1, 1'b0, 32'h010, 32'h0,         1'b1, 1'b1, 32'h00000000, 17, 16};
      vecs[13] = '{1'b1, 1'b0, 32'h201, 32'h0,         1'b0, 1'b1, 32'h00000000, 1,  0};

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_if_done",  {31'b0, if_done}, 32'h0);
      check("rst_if_err",   {31'b0, if_err}, 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_d_done",   {31'b0, d_done}, 32'h0);
      check("rst_d_err",    {31'b0, d_err}, 32'h0);
      check("rst_d_rdata",  d_rdata, 32'h0);
      check("rst_valid",    {31'b0, mem_bus.mem_req_valid}, 32'h0);
      check("rst_addr",     mem_bus.mem_req_addr, 32'h0);
      check("rst_rw",       {31'b0, mem_bus.mem_req_rw}, 32'h0);
      check("rst_wdata",    mem_bus.mem_data_write, 32'h0);
      RESETn = 1'b1;

      // Tie right after reset: if, d, if, d at cycles 3, 7, 11, 15
      @(negedge CLK);
      if_req = 1'b1; if_addr = 32'h004;
      d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h200;
      for (int c = 1; c <= 16; c++) begin
         @(negedge CLK);
         check($sformatf("tie_if_done_c%0d", c), {31'b0, if_done}, {31'b0, (c == 3 || c == 11)});
         check($sformatf("tie_d_done_c%0d", c), {31'b0, d_done}, {31'b0, (c == 7 || c == 15)});
         if (c == 3) check("tie_if_rdata", if_rdata, 32'hE59F2200);
         if (c == 7) check("tie_d_rdata", d_rdata, 32'h00000810);
         if (c == 15) begin if_req = 1'b0; d_req = 1'b0; end
      end

      // Single-port vectors
      for (int i = 0; i < NV; i++) begin
         int lat;
         int vcnt;
         logic got_d;
         lat = -1;
         vcnt = 0;
         got_d = 1'b0;
         stall = vecs[i].stall;
         if (vecs[i].is_d) begin
            d_req = 1'b1; d_rw = vecs[i].rw; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
         end else begin
            if_req = 1'b1; if_addr = vecs[i].addr;
         end
         for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (mem_bus.mem_req_valid) begin
               if (vcnt == 0) begin
                  check($sformatf("v%0d_mem_addr", i), mem_bus.mem_req_addr, vecs[i].addr);
                  check($sformatf("v%0d_mem_rw", i), {31'b0, mem_bus.mem_req_rw}, {31'b0, vecs[i].rw});
                  if (vecs[i].rw)
                     check($sformatf("v%0d_mem_wdata", i), mem_bus.mem_data_write, vecs[i].wdata);
               end
               vcnt++;
            end
            if (if_done || d_done) begin
               lat = c;
               got_d = d_done;
               break;
            end
         end
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("v%0d_done_port", i), {31'b0, got_d}, {31'b0, vecs[i].is_d});
         check($sformatf("v%0d_err", i), {31'b0, vecs[i].is_d ? d_err : if_err}, {31'b0, vecs[i].exp_err});
         check($sformatf("v%0d_rdata", i), vecs[i].is_d ? d_rdata : if_rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_valid_cycles", i), 32'(vcnt), 32'(vecs[i].exp_vcnt));
         if_req = 1'b0;
         d_req = 1'b0;
         stall = 1'b0;
         @(negedge CLK);
         check($sformatf("v%0d_done_single", i), {30'b0, if_done, d_done}, 32'h0);
         check($sformatf("v%0d_valid_after", i), {31'b0, mem_bus.mem_req_valid}, 32'h0);
      end

      // Reset while in ISSUE
      d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h200;
      @(negedge CLK);
      check("mid_valid_before", {31'b0, mem_bus.mem_req_valid}, 32'h1);
      RESETn = 1'b0;
      #1;
      check("mid_valid_async", {31'b0, mem_bus.mem_req_valid}, 32'h0);
      check("mid_if_rdata_async", if_rdata, 32'h0);
      d_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check($sformatf("mid_no_done_%0d", c), {30'b0, if_done, d_done}, 32'h0);
      end
      RESETn = 1'b1;
      if_req = 1'b1; if_addr = 32'h004;
      d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h200;
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         check($sformatf("post_if_done_c%0d", c), {31'b0, if_done}, {31'b0, (c == 3)});
         check($sformatf("post_d_done_c%0d", c), {31'b0, d_done}, 32'h0);
         if (c == 3) begin
            check("post_if_rdata", if_rdata, 32'hE59F2200);
            if_req = 1'b0;
            d_req = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
